// File: rtl/dm_arbiter.sv
// ---------------------------------------------------------------------------
// dm_arbiter
//
// Purpose:
//   Round-robin arbiter that lets two masters share a single-port data
//   memory. The memory has a combinational word read and writes on the
//   rising clock edge. Master 0 is the CPU MEM stage, master 1 is a
//   secondary requester (DMA / debug loader). Each granted access lasts
//   exactly one cycle. Misaligned or out-of-range accesses are acknowledged
//   with an error flag and never reach the memory as a write.
//
// Ports:
//   Clk                 clock, all state changes on the rising edge
//   Reset               synchronous, active-high reset
//   Req0/We0/Addr0/WData0  master 0 request, write enable, byte address, data
//   Ack0/Err0/RData0       master 0 completion pulse, reject flag, read data
//   Stall0                 master 0 waiting (Req0 & ~Ack0), freezes the CPU
//   Req1/We1/Addr1/WData1  master 1 request, write enable, byte address, data
//   Ack1/Err1/RData1       master 1 completion pulse, reject flag, read data
//   MemAddr/MemData        byte address and write data to the data memory
//   MemWrite               write enable to the data memory
//   MemOut                 combinational read data from the data memory
// ---------------------------------------------------------------------------
module dm_arbiter #(
  parameter int DEPTH_LOG2 = 10
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        Req0,
  input  logic        We0,
  input  logic [31:0] Addr0,
  input  logic [31:0] WData0,
  output logic        Ack0,
  output logic        Err0,
  output logic [31:0] RData0,
  output logic        Stall0,
  input  logic        Req1,
  input  logic        We1,
  input  logic [31:0] Addr1,
  input  logic [31:0] WData1,
  output logic        Ack1,
  output logic        Err1,
  output logic [31:0] RData1,
  output logic [31:0] MemAddr,
  output logic [31:0] MemData,
  output logic        MemWrite,
  input  logic [31:0] MemOut
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    GNT0 = 2'd1,
    GNT1 = 2'd2
  } state_t;

  state_t r_state;
  state_t w_next;
  logic   r_last;
  logic   w_bad0;
  logic   w_bad1;
  logic   w_ack0;

  // An access is rejected when it is not word aligned or when any address
  // bit above the memory's byte range is set.
  assign w_bad0 = (Addr0[1:0] != 2'b00) | (Addr0[31:DEPTH_LOG2+2] != '0);
  assign w_bad1 = (Addr1[1:0] != 2'b00) | (Addr1[31:DEPTH_LOG2+2] != '0);

  // State register plus the record of who was served last. Last resets to
  // master 1 so that master 0 wins the very first tie.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_state <= IDLE;
      r_last  <= 1'b1;
    end else begin
      r_state <= w_next;
      if (r_state == GNT0) begin
        r_last <= 1'b0;
      end else if (r_state == GNT1) begin
        r_last <= 1'b1;
      end
    end
  end

  // Next-state selection. A grant always lasts one cycle; afterwards the
  // other master is served back-to-back if it is waiting, otherwise we go
  // back to IDLE so that a still-high request is arbitrated afresh.
  always_comb begin
    w_next = IDLE;
    case (r_state)
      IDLE: begin
        if (Req0 && Req1) begin
          w_next = r_last ? GNT0 : GNT1;
        end else if (Req0) begin
          w_next = GNT0;
        end else if (Req1) begin
          w_next = GNT1;
        end
      end
      GNT0: begin
        if (Req1) begin
          w_next = GNT1;
        end
      end
      GNT1: begin
        if (Req0) begin
          w_next = GNT0;
        end
      end
      default: w_next = IDLE;
    endcase
  end

  // Memory port and master responses. Everything is forced quiet while
  // Reset is high so a grant in progress is dropped without a write.
  always_comb begin
    w_ack0   = 1'b0;
    Err0     = 1'b0;
    RData0   = '0;
    Ack1     = 1'b0;
    Err1     = 1'b0;
    RData1   = '0;
    MemAddr  = '0;
    MemData  = '0;
    MemWrite = 1'b0;
    if (!Reset) begin
      case (r_state)
        GNT0: begin
          w_ack0   = 1'b1;
          MemAddr  = Addr0;
          MemData  = WData0;
          MemWrite = We0 & ~w_bad0;
          Err0     = w_bad0;
          RData0   = w_bad0 ? '0 : MemOut;
        end
        GNT1: begin
          Ack1     = 1'b1;
          MemAddr  = Addr1;
          MemData  = WData1;
          MemWrite = We1 & ~w_bad1;
          Err1     = w_bad1;
          RData1   = w_bad1 ? '0 : MemOut;
        end
        default: begin
        end
      endcase
    end
  end

  assign Ack0   = w_ack0;
  assign Stall0 = Req0 & ~w_ack0;

endmodule

// File: tb/tb_dm_arbiter.sv
// ---------------------------------------------------------------------------
// tb_dm_arbiter
//
// Purpose:
//   Self-checking bench for dm_arbiter. Hosts a 1024-word data memory,
//   drives both masters and compares every DUT output each cycle with a
//   reference model that tracks which master is served and the memory
//   contents the masters should observe.
//
// Ports: none (top-level bench).
// ---------------------------------------------------------------------------
module tb_dm_arbiter;

  logic        Clk = 1'b0;
  logic        Reset;
  logic        Req0, We0, Req1, We1;
  logic [31:0] Addr0, WData0, Addr1, WData1;
  logic        Ack0, Err0, Stall0, Ack1, Err1, MemWrite;
  logic [31:0] RData0, RData1, MemAddr, MemData, MemOut;

  int checks = 0;
  int errors = 0;

  // Memory seen by the DUT and the memory the masters expect to see.
  logic [31:0] devMem [1024];
  logic [31:0] refMem [1024];

  // Who the model says is served in the current cycle (-1 none).
  int servedNow  = -1;
  int lastServed = 1;

  logic        eAck0, eErr0, eAck1, eErr1, eMw, eSt0;
  logic [31:0] eRd0, eRd1, eMa, eMd;

  typedef struct {
    logic        rst;
    logic        q0;
    logic        w0;
    logic [31:0] a0;
    logic [31:0] d0;
    logic        q1;
    logic        w1;
    logic [31:0] a1;
    logic [31:0] d1;
    logic        xAck0;
    logic        xErr0;
    logic [31:0] xRd0;
    logic        xAck1;
    logic        xErr1;
    logic [31:0] xRd1;
    logic        xMw;
    logic [31:0] xMa;
    logic [31:0] xMd;
    logic        xSt0;
  } vec_t;

  vec_t tbl [18];

  dm_arbiter #(.DEPTH_LOG2(10)) dut (
    .Clk(Clk), .Reset(Reset),
    .Req0(Req0), .We0(We0), .Addr0(Addr0), .WData0(WData0),
    .Ack0(Ack0), .Err0(Err0), .RData0(RData0), .Stall0(Stall0),
    .Req1(Req1), .We1(We1), .Addr1(Addr1), .WData1(WData1),
    .Ack1(Ack1), .Err1(Err1), .RData1(RData1),
    .MemAddr(MemAddr), .MemData(MemData), .MemWrite(MemWrite),
    .MemOut(MemOut)
  );

  always #5 Clk = ~Clk;

  // The data memory itself: combinational read, write on the rising edge.
  assign MemOut = devMem[MemAddr[11:2]];

  always @(posedge Clk) begin
    if (MemWrite) devMem[MemAddr[11:2]] = MemData;
  end

  function automatic bit isBad(input logic [31:0] a);
    return (a % 4 != 0) || (a >= 32'd4096);
  endfunction

  // Reference model: advance who is served and apply the served write.
  always @(posedge Clk) begin
    if (Reset) begin
      servedNow  = -1;
      lastServed = 1;
    end else if (servedNow == 0) begin
      if (We0 && !isBad(Addr0)) refMem[Addr0 / 4] = WData0;
      lastServed = 0;
      servedNow  = Req1 ? 1 : -1;
    end else if (servedNow == 1) begin
      if (We1 && !isBad(Addr1)) refMem[Addr1 / 4] = WData1;
      lastServed = 1;
      servedNow  = Req0 ? 0 : -1;
    end else if (Req0 && Req1) begin
      servedNow = 1 - lastServed;
    end else if (Req0) begin
      servedNow = 0;
    end else if (Req1) begin
      servedNow = 1;
    end else begin
      servedNow = -1;
    end
  end

  task automatic computeExpected;
    eAck0 = 1'b0; eErr0 = 1'b0; eRd0 = '0;
    eAck1 = 1'b0; eErr1 = 1'b0; eRd1 = '0;
    eMw = 1'b0; eMa = '0; eMd = '0;
    if (!Reset && servedNow == 0) begin
      eAck0 = 1'b1; eErr0 = isBad(Addr0);
      eRd0  = eErr0 ? '0 : refMem[Addr0 / 4];
      eMa = Addr0; eMd = WData0; eMw = We0 && !eErr0;
    end else if (!Reset && servedNow == 1) begin
      eAck1 = 1'b1; eErr1 = isBad(Addr1);
      eRd1  = eErr1 ? '0 : refMem[Addr1 / 4];
      eMa = Addr1; eMd = WData1; eMw = We1 && !eErr1;
    end
    eSt0 = Req0 && !eAck0;
  endtask

  task automatic checkBit(input string nm, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %b expected %b at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic checkWord(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic checkModel;
    computeExpected();
    checkBit("model Ack0", Ack0, eAck0);
    checkBit("model Err0", Err0, eErr0);
    checkWord("model RData0", RData0, eRd0);
    checkBit("model Ack1", Ack1, eAck1);
    checkBit("model Err1", Err1, eErr1);
    checkWord("model RData1", RData1, eRd1);
    checkBit("model MemWrite", MemWrite, eMw);
    checkWord("model MemAddr", MemAddr, eMa);
    checkWord("model MemData", MemData, eMd);
    checkBit("model Stall0", Stall0, eSt0);
  endtask

  task automatic applyStimulus(input vec_t v);
    Reset = v.rst;
    Req0 = v.q0; We0 = v.w0; Addr0 = v.a0; WData0 = v.d0;
    Req1 = v.q1; We1 = v.w1; Addr1 = v.a1; WData1 = v.d1;
  endtask

  task automatic checkOutput(input vec_t v, input int row);
    string p;
    p = $sformatf("tbl[%0d]", row);
    checkBit({p, " Ack0"}, Ack0, v.xAck0);
    checkBit({p, " Err0"}, Err0, v.xErr0);
    checkWord({p, " RData0"}, RData0, v.xRd0);
    checkBit({p, " Ack1"}, Ack1, v.xAck1);
    checkBit({p, " Err1"}, Err1, v.xErr1);
    checkWord({p, " RData1"}, RData1, v.xRd1);
    checkBit({p, " MemWrite"}, MemWrite, v.xMw);
    checkWord({p, " MemAddr"}, MemAddr, v.xMa);
    checkWord({p, " MemData"}, MemData, v.xMd);
    checkBit({p, " Stall0"}, Stall0, v.xSt0);
  endtask

  function automatic logic [31:0] randAddr();
    case ($urandom_range(0, 3))
      0, 1:    return 32'($urandom_range(0, 15)) * 32'd4;
      2:       return 32'($urandom_range(0, 63));
      default: return 32'h1000 + (32'($urandom_range(0, 1023)) * 32'd4);
    endcase
  endfunction

  localparam logic [31:0] DB  = 32'hDEADBEEF;
  localparam logic [31:0] AB  = 32'hAAAA5555;
  localparam logic [31:0] IV1 = 32'h1000_0001;
  localparam logic [31:0] IV4 = 32'h1000_0004;
  localparam logic [31:0] A10 = 32'h10;
  localparam logic [31:0] A4  = 32'h4;
  localparam logic [31:0] Z   = 32'h0;

  logic prevAck0, prevAck1;

  // Stimulus: inputs change on the falling edge, outputs are sampled 1ns
  // later, the DUT and the model both advance on the rising edge.
  initial begin
    for (int i = 0; i < 1024; i++) begin
      devMem[i] = 32'h1000_0000 + 32'(i);
      refMem[i] = 32'h1000_0000 + 32'(i);
    end

    //              rst   q0    w0    a0    d0  q1    w1    a1    d1  Ack0  Err0  Rd0  Ack1  Err1  Rd1  Mw    Ma   Md  St0
    tbl[0]  = '{1'b1, 1'b0, 1'b0, Z,   Z,  1'b0, 1'b0, Z,   Z,  1'b0, 1'b0, Z,   1'b0, 1'b0, Z,   1'b0, Z,   Z,  1'b0};
    tbl[1]  = '{1'b0, 1'b1, 1'b1, A10, DB, 1'b0, 1'b0, Z,   Z,  1'b0, 1'b0, Z,   1'b0, 1'b0, Z,   1'b0, Z,   Z,  1'b1};
    tbl[2]  = '{1'b0, 1'b1, 1'b1, A10, DB, 1'b0, 1'b0, Z,   Z,  1'b1, 1'b0, IV4, 1'b0, 1'b0, Z,   1'b1, A10, DB, 1'b0};
    tbl[3]  = '{1'b0, 1'b1, 1'b0, A10, Z,  1'b0, 1'b0, Z,   Z,  1'b0, 1'b0, Z,   1'b0, 1'b0, Z,   1'b0, Z,   Z,  1'b1};
    tbl[4]  = '{1'b0, 1'b1, 1'b0, A10, Z,  1'b0, 1'b0, Z,   Z,  1'b1, 1'b0, DB,  1'b0, 1'b0, Z,   1'b0, A10, Z,  1'b0};
    tbl[5]  = '{1'b0, 1'b1, 1'b0, A10, Z,  1'b1, 1'b0, A4,  Z,  1'b0, 1'b0, Z,   1'b0, 1'b0, Z,   1'b0, Z,   Z,  1'b1};
    tbl[6]  = '{1'b0, 1'b1, 1'b0, A10, Z,  1'b1, 1'b0, A4,  Z,  1'b0, 1'b0, Z,   1'b1, 1'b0, IV1, 1'b0, A4,  Z,  1'b1};
    tbl[7]  = '{1'b0, 1'b1, 1'b0, A10, Z,  1'b1, 1'b0, A4,  Z,  1'b1, 1'b0, DB,  1'b0, 1'b0, Z,   1'b0, A10, Z,  1'b0};
    tbl[8]  = tbl[6];
    tbl[9]  = tbl[7];
    tbl[10] = tbl[6];
    tbl[11] = '{1'b0, 1'b0, 1'b0, A10, Z,  1'b0, 1'b0, A4,  Z,  1'b1, 1'b0, DB,  1'b0, 1'b0, Z,   1'b0, A10, Z,  1'b0};
    tbl[12] = '{1'b0, 1'b0, 1'b0, Z,   Z,  1'b1, 1'b1, 32'h6, AB, 1'b0, 1'b0, Z, 1'b0, 1'b0, Z,   1'b0, Z,   Z,  1'b0};
    tbl[13] = '{1'b0, 1'b0, 1'b0, Z,   Z,  1'b1, 1'b1, 32'h6, AB, 1'b0, 1'b0, Z, 1'b1, 1'b1, Z,   1'b0, 32'h6, AB, 1'b0};
    tbl[14] = '{1'b0, 1'b0, 1'b0, Z,   Z,  1'b1, 1'b1, 32'h1000, AB, 1'b0, 1'b0, Z, 1'b0, 1'b0, Z, 1'b0, Z,   Z,  1'b0};
    tbl[15] = '{1'b0, 1'b0, 1'b0, Z,   Z,  1'b1, 1'b1, 32'h1000, AB, 1'b0, 1'b0, Z, 1'b1, 1'b1, Z, 1'b0, 32'h1000, AB, 1'b0};
    tbl[16] = '{1'b0, 1'b0, 1'b0, Z,   Z,  1'b1, 1'b0, A4,  Z,  1'b0, 1'b0, Z,   1'b0, 1'b0, Z,   1'b0, Z,   Z,  1'b0};
    tbl[17] = '{1'b0, 1'b0, 1'b0, Z,   Z,  1'b1, 1'b0, A4,  Z,  1'b0, 1'b0, Z,   1'b1, 1'b0, IV1, 1'b0, A4,  Z,  1'b0};

    // Two reset cycles with both masters requesting, then strict
    // alternation starting with master 0 and no idle bubble.
    Reset = 1'b1;
    Req0 = 1'b1; We0 = 1'b0; Addr0 = 32'h8;  WData0 = '0;
    Req1 = 1'b1; We1 = 1'b0; Addr1 = 32'hC;  WData1 = '0;
    for (int c = 0; c < 2; c++) begin
      if (c > 0) @(negedge Clk);
      #1;
      checkModel();
      checkBit("reset Ack0", Ack0, 1'b0);
      checkBit("reset Ack1", Ack1, 1'b0);
      checkBit("reset MemWrite", MemWrite, 1'b0);
    end
    @(negedge Clk);
    Reset = 1'b0;
    #1;
    checkModel();
    checkBit("post-reset idle Ack0", Ack0, 1'b0);
    for (int k = 0; k < 6; k++) begin
      @(negedge Clk);
      #1;
      checkModel();
      checkBit($sformatf("alternate Ack0 #%0d", k), Ack0, (k % 2) == 0);
      checkBit($sformatf("alternate Ack1 #%0d", k), Ack1, (k % 2) == 1);
    end

    // Table vectors, starting from a reset cycle.
    for (int i = 0; i < 18; i++) begin
      @(negedge Clk);
      applyStimulus(tbl[i]);
      #1;
      checkOutput(tbl[i], i);
      checkModel();
    end

    // Reset landing on a GNT1 write cycle: the write must be dropped.
    @(negedge Clk);
    Req0 = 1'b0; Req1 = 1'b1; We1 = 1'b1; Addr1 = 32'h20; WData1 = 32'h12345678;
    #1; checkModel();
    @(negedge Clk);
    Reset = 1'b1;
    #1; checkModel();
    checkBit("rst-in-gnt Ack1", Ack1, 1'b0);
    checkBit("rst-in-gnt MemWrite", MemWrite, 1'b0);
    @(negedge Clk);
    Reset = 1'b0; Req1 = 1'b0; We1 = 1'b0;
    #1; checkModel();
    checkBit("after-rst Ack1", Ack1, 1'b0);
    @(negedge Clk);
    Req0 = 1'b1; We0 = 1'b0; Addr0 = 32'h20;
    #1; checkModel();
    @(negedge Clk);
    #1; checkModel();
    checkBit("readback 0x20 Ack0", Ack0, 1'b1);
    checkWord("readback 0x20 RData0", RData0, 32'h1000_0008);

    // Master 1 alone holding its request: one access every other cycle.
    @(negedge Clk);
    Req0 = 1'b0;
    #1; checkModel();
    for (int k = 0; k < 4; k++) begin
      @(negedge Clk);
      Req1 = 1'b1; We1 = 1'b0; Addr1 = 32'h8;
      #1; checkModel();
      checkBit($sformatf("held Req1 Ack1 #%0d", k), Ack1, (k % 2) == 1);
      checkBit($sformatf("held Req1 Ack0 #%0d", k), Ack0, 1'b0);
    end

    // Randomised traffic from two mostly well-behaved masters.
    prevAck0 = eAck0;
    prevAck1 = eAck1;
    for (int c = 0; c < 800; c++) begin
      @(negedge Clk);
      Reset = ($urandom_range(0, 63) == 0);
      if (Req0 && prevAck0) Req0 = 1'b0;
      else if (Req0 && $urandom_range(0, 15) == 0) Req0 = 1'b0;
      else if (!Req0 && $urandom_range(0, 1) == 1) begin
        Req0 = 1'b1; We0 = 1'($urandom_range(0, 1));
        Addr0 = randAddr(); WData0 = $urandom;
      end
      if (Req1 && prevAck1) Req1 = 1'b0;
      else if (Req1 && $urandom_range(0, 15) == 0) Req1 = 1'b0;
      else if (!Req1 && $urandom_range(0, 1) == 1) begin
        Req1 = 1'b1; We1 = 1'($urandom_range(0, 1));
        Addr1 = randAddr(); WData1 = $urandom;
      end
      #1;
      checkModel();
      prevAck0 = eAck0;
      prevAck1 = eAck1;
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
